// File: rtl/serial_rx_ack_pkg.sv
// Shared constants and state encodings for the serial flit link receive end.
package link_pkg;

  localparam int LINK_DATA_W = 55;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic ACK_CODE  = 1'b1;
  localparam logic NAK_CODE  = 1'b0;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_PAR,
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_START,
    A_CODE
  } ack_state_t;

endpackage

// File: rtl/serial_rx_ack_if.sv
// Serial link pins plus the parallel valid/ready flit port and error status.
interface serial_rx_ack_if
  import link_pkg::*;
#(
  parameter int DATA_W    = LINK_DATA_W,
  parameter int ERR_CNT_W = 8
);
  logic                 S_Data;
  logic                 RX_Ready;
  logic [DATA_W-1:0]    RX_Data;
  logic                 RX_Data_Valid;
  logic                 S_Ack;
  logic                 Parity_Err;
  logic                 Frame_Err;
  logic                 Overrun;
  logic [ERR_CNT_W-1:0] Err_Count;

  modport slave (
    input  S_Data, RX_Ready,
    output RX_Data, RX_Data_Valid, S_Ack, Parity_Err, Frame_Err, Overrun, Err_Count
  );

  modport master (
    output S_Data, RX_Ready,
    input  RX_Data, RX_Data_Valid, S_Ack, Parity_Err, Frame_Err, Overrun, Err_Count
  );
endinterface

// File: rtl/serial_rx_ack_ack_serializer.sv
// Emits the 2-bit reverse ACK/NAK frame: start bit, then code bit, then idle low.
module ack_serializer
  import link_pkg::*;
(
  input  logic Clk_S,
  input  logic Rst,
  input  logic i_send,
  input  logic i_code,
  output logic o_s_ack
);

  ack_state_t r_state, w_state_next;
  logic       r_code, w_code_next;
  logic       r_s_ack, w_s_ack_next;

  always_ff @(posedge Clk_S or posedge Rst) begin
    if (Rst) begin
      r_state <= A_IDLE;
      r_code  <= NAK_CODE;
      r_s_ack <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_s_ack <= w_s_ack_next;
    end
  end

  // The start bit is registered on the send edge so it appears the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_s_ack_next = 1'b0;
    case (r_state)
      A_IDLE: begin
        if (i_send) begin
          w_state_next = A_START;
          w_code_next  = i_code;
          w_s_ack_next = START_BIT;
        end
      end
      A_START: begin
        w_state_next = A_CODE;
        w_s_ack_next = r_code;
      end
      A_CODE: begin
        w_state_next = A_IDLE;
      end
      default: begin
        w_state_next = A_IDLE;
      end
    endcase
  end

  assign o_s_ack = r_s_ack;

endmodule

// File: rtl/serial_rx_ack.sv
// Receive end of the serial flit link: deframes, checks parity/stop bit,
// buffers one flit for the core and answers each frame with ACK or NAK.
module serial_rx_ack
  import link_pkg::*;
#(
  parameter int DATA_W    = LINK_DATA_W,
  parameter int ERR_CNT_W = 8
)(
  input  logic            Clk_S,
  input  logic            Rst,
  serial_rx_ack_if.slave  bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_t            r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_W-1:0]    r_shift;
  logic [DATA_W-1:0]    r_data;
  logic                 r_par_run;
  logic                 r_par_bad;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic w_stop_edge;
  logic w_drain;
  logic w_frame_bad;
  logic w_parity_bad;
  logic w_overrun;
  logic w_load;
  logic w_nak;
  logic w_s_ack;

  // Stop-edge priority: framing, then parity, then buffer-full.
  assign w_stop_edge  = (r_state == R_STOP);
  assign w_drain      = r_valid & bus.RX_Ready;
  assign w_frame_bad  = w_stop_edge & (bus.S_Data != STOP_BIT);
  assign w_parity_bad = w_stop_edge & ~w_frame_bad & r_par_bad;
  assign w_overrun    = w_stop_edge & ~w_frame_bad & ~r_par_bad & r_valid & ~bus.RX_Ready;
  assign w_load       = w_stop_edge & ~w_frame_bad & ~r_par_bad & ~w_overrun;
  assign w_nak        = w_frame_bad | w_parity_bad | w_overrun;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      R_IDLE:  if (bus.S_Data == START_BIT) w_state_next = R_DATA;
      R_DATA:  if (r_cnt == CNT_LAST) w_state_next = R_PAR;
      R_PAR:   w_state_next = R_STOP;
      R_STOP:  w_state_next = R_IDLE;
      default: w_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge Clk_S or posedge Rst) begin
    if (Rst) begin
      r_state      <= R_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_par_run    <= 1'b0;
      r_par_bad    <= 1'b0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_parity_err <= w_parity_bad;
      r_frame_err  <= w_frame_bad;
      r_overrun    <= w_overrun;

      case (r_state)
        R_IDLE: begin
          r_cnt     <= '0;
          r_par_run <= 1'b0;
        end
        R_DATA: begin
          r_shift[r_cnt] <= bus.S_Data;
          r_par_run      <= r_par_run ^ bus.S_Data;
          if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
        end
        R_PAR: begin
          r_par_bad <= r_par_run ^ bus.S_Data;
        end
        default: begin
        end
      endcase

      // A load on a draining edge replaces the old flit and keeps valid high.
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end

      if (w_nak && (r_err_cnt != {ERR_CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  ack_serializer u_ack (
    .Clk_S   (Clk_S),
    .Rst     (Rst),
    .i_send  (w_stop_edge),
    .i_code  (w_load ? ACK_CODE : NAK_CODE),
    .o_s_ack (w_s_ack)
  );

  assign bus.RX_Data       = r_data;
  assign bus.RX_Data_Valid = r_valid;
  assign bus.S_Ack         = w_s_ack;
  assign bus.Parity_Err    = r_parity_err;
  assign bus.Frame_Err     = r_frame_err;
  assign bus.Overrun       = r_overrun;
  assign bus.Err_Count     = r_err_cnt;

endmodule
